pipe_ctrl: RTL and testbench

//   Central stall/flush scheduler for the 5-stage integer pipeline.
//   - Merges load-use nop, EX-stage jump, multicycle-unit (mul/div) busy and data-bus wait into per-stage hold/flush controls and one PC redirect.
//   - Owns the multicycle wait FSM with timeout, and the post-redirect bubble sequencer.
//   - Sits beside the hazard detector; drives the PC register and the IF_ID, ID_EX and EX_MEM pipeline registers.

---
 rtl/pipe_ctrl_if.sv | 41 ++++
 rtl/pipe_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the hazard/EX side and the pipeline stall/flush scheduler.
interface pipe_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned CNT_W = 32;

    logic              load_use_nop;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              mc_start;
    logic              mc_done;
    logic              mem_wait;

    logic              pc_hold;
    logic              if_id_hold;
    logic              if_id_flush;
    logic              id_ex_hold;
    logic              id_ex_flush;
    logic              ex_mem_hold;
    logic              ex_mem_flush;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_addr;
    logic              mc_timeout;
    logic [CNT_W-1:0]  stall_cnt;

    // Pipeline side: raises hazards, consumes the stage controls.
    modport master (
        output load_use_nop, jump_en, jump_addr, mc_start, mc_done, mem_wait,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
               ex_mem_hold, ex_mem_flush, redirect_en, redirect_addr,
               mc_timeout, stall_cnt
    );

    // Scheduler side.
    modport slave (
        input  load_use_nop, jump_en, jump_addr, mc_start, mc_done, mem_wait,
        output pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
               ex_mem_hold, ex_mem_flush, redirect_en, redirect_addr,
               mc_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage integer pipeline.
// Merges load-use, EX jump, multicycle busy and data-bus wait into per-stage
// hold/flush controls plus one PC redirect. Controls are Mealy (zero latency).
// Optional build macro PIPE_CTRL_PERF_EN: adds the pc_hold cycle counter on stall_cnt.
module pipe_ctrl #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    localparam int unsigned MC_W  = $clog2(MC_TIMEOUT);
    localparam int unsigned RD_W  = 2;
    localparam int unsigned CNT_W = 32;

    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_TIMEOUT - 1);
    localparam logic [RD_W-1:0] RD_LOAD = RD_W'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        REDIR   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;

    logic              pc_hold_c;
    logic              if_id_hold_c;
    logic              if_id_flush_c;
    logic              id_ex_hold_c;
    logic              id_ex_flush_c;
    logic              ex_mem_hold_c;
    logic              ex_mem_flush_c;
    logic              redirect_en_c;
    logic [ADDR_W-1:0] redirect_addr_c;
    logic              mc_timeout_c;

    // State and counter registers; reset abandons any wait or redirect silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            mc_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Next-state and stage controls; mem_wait freezes everything, outputs forced low in reset.
    always_comb begin
        state_d         = state_q;
        mc_cnt_d        = mc_cnt_q;
        rd_cnt_d        = rd_cnt_q;
        pc_hold_c       = 1'b0;
        if_id_hold_c    = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_hold_c    = 1'b0;
        id_ex_flush_c   = 1'b0;
        ex_mem_hold_c   = 1'b0;
        ex_mem_flush_c  = 1'b0;
        redirect_en_c   = 1'b0;
        redirect_addr_c = '0;
        mc_timeout_c    = 1'b0;

        if (rst_n) begin
            if (bus.mem_wait) begin
                pc_hold_c     = 1'b1;
                if_id_hold_c  = 1'b1;
                id_ex_hold_c  = 1'b1;
                ex_mem_hold_c = 1'b1;
            end else begin
                case (state_q)
                    RUN: begin
                        if (bus.mc_start) begin
                            pc_hold_c      = 1'b1;
                            if_id_hold_c   = 1'b1;
                            id_ex_hold_c   = 1'b1;
                            ex_mem_flush_c = 1'b1;
                            mc_cnt_d       = '0;
                            state_d        = MC_WAIT;
                        end else if (bus.jump_en) begin
                            redirect_en_c   = 1'b1;
                            redirect_addr_c = bus.jump_addr;
                            if_id_flush_c   = 1'b1;
                            id_ex_flush_c   = 1'b1;
                            if (FLUSH_CYCLES != 0) begin
                                rd_cnt_d = RD_LOAD;
                                state_d  = REDIR;
                            end
                        end else if (bus.load_use_nop) begin
                            pc_hold_c     = 1'b1;
                            if_id_hold_c  = 1'b1;
                            id_ex_flush_c = 1'b1;
                        end
                    end
                    MC_WAIT: begin
                        if (bus.mc_done) begin
                            // Result advances into EX_MEM; done beats a same-cycle timeout.
                            state_d = RUN;
                        end else if (mc_cnt_q == MC_LAST) begin
                            mc_timeout_c   = 1'b1;
                            ex_mem_flush_c = 1'b1;
                            state_d        = RUN;
                        end else begin
                            pc_hold_c      = 1'b1;
                            if_id_hold_c   = 1'b1;
                            id_ex_hold_c   = 1'b1;
                            ex_mem_flush_c = 1'b1;
                            mc_cnt_d       = mc_cnt_q + MC_W'(1);
                        end
                    end
                    REDIR: begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        if (bus.jump_en) begin
                            redirect_en_c   = 1'b1;
                            redirect_addr_c = bus.jump_addr;
                            rd_cnt_d        = RD_LOAD;
                        end else if (rd_cnt_q <= RD_W'(1)) begin
                            rd_cnt_d = '0;
                            state_d  = RUN;
                        end else begin
                            rd_cnt_d = rd_cnt_q - RD_W'(1);
                        end
                    end
                    default: begin
                        state_d = RUN;
                    end
                endcase
            end
        end
    end

    assign bus.pc_hold       = pc_hold_c;
    assign bus.if_id_hold    = if_id_hold_c;
    assign bus.if_id_flush   = if_id_flush_c;
    assign bus.id_ex_hold    = id_ex_hold_c;
    assign bus.id_ex_flush   = id_ex_flush_c;
    assign bus.ex_mem_hold   = ex_mem_hold_c;
    assign bus.ex_mem_flush  = ex_mem_flush_c;
    assign bus.redirect_en   = redirect_en_c;
    assign bus.redirect_addr = redirect_addr_c;
    assign bus.mc_timeout    = mc_timeout_c;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count every cycle the PC is held, bus-wait cycles included; wraps naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_hold_c) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Performance counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the scheduling rules.
module tb_pipe_ctrl;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned FC     = 1;
    localparam int unsigned TO     = 8;

    logic clk;
    logic rst_n;

    pipe_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    pipe_ctrl #(
        .ADDR_W      (ADDR_W),
        .FLUSH_CYCLES(FC),
        .MC_TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int cyc;

    // Behavioural model: what the pipeline is currently doing.
    bit          m_mc_busy;      // a multicycle op is outstanding
    int          m_mc_waited;    // wait cycles already spent after issue
    int          m_bubbles_left; // post-redirect bubble cycles still owed
    int unsigned m_stalls;       // cycles the PC was held

    // Expected outputs for the current cycle.
    // Order: pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
    //        ex_mem_hold, ex_mem_flush, redirect_en, mc_timeout
    logic [8:0]        exp_vec;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_stall;

    function automatic logic [8:0] act_vec();
        return {bus.pc_hold, bus.if_id_hold, bus.if_id_flush, bus.id_ex_hold,
                bus.id_ex_flush, bus.ex_mem_hold, bus.ex_mem_flush,
                bus.redirect_en, bus.mc_timeout};
    endfunction

    // Stimulus word: {mem_wait, mc_done, mc_start, jump_en, load_use_nop}
    task automatic drive(input logic [4:0] s, input logic [ADDR_W-1:0] addr);
        bus.mem_wait     = s[4];
        bus.mc_done      = s[3];
        bus.mc_start     = s[2];
        bus.jump_en      = s[1];
        bus.load_use_nop = s[0];
        bus.jump_addr    = addr;
    endtask

    task automatic model_clear();
        m_mc_busy      = 1'b0;
        m_mc_waited    = 0;
        m_bubbles_left = 0;
        m_stalls       = 0;
    endtask

    // Derive this cycle's expected controls from the rules, then advance the model.
    task automatic predict();
        bit ph, ihh, ihf, ieh, ief, emh, emf, rd, tmo;
        {ph, ihh, ihf, ieh, ief, emh, emf, rd, tmo} = '0;
        exp_addr = '0;
`ifdef PIPE_CTRL_PERF_EN
        exp_stall = m_stalls;
`else
        exp_stall = 32'd0;
`endif
        if (bus.mem_wait) begin
            ph = 1; ihh = 1; ieh = 1; emh = 1;
        end else if (m_bubbles_left > 0) begin
            ihf = 1; ief = 1;
            if (bus.jump_en) begin
                rd = 1; exp_addr = bus.jump_addr;
                m_bubbles_left = FC;
            end else begin
                m_bubbles_left = m_bubbles_left - 1;
            end
        end else if (m_mc_busy) begin
            if (bus.mc_done) begin
                m_mc_busy = 0;
            end else if (m_mc_waited == TO - 1) begin
                tmo = 1; emf = 1;
                m_mc_busy = 0;
            end else begin
                ph = 1; ihh = 1; ieh = 1; emf = 1;
                m_mc_waited = m_mc_waited + 1;
            end
        end else if (bus.mc_start) begin
            ph = 1; ihh = 1; ieh = 1; emf = 1;
            m_mc_busy = 1; m_mc_waited = 0;
        end else if (bus.jump_en) begin
            rd = 1; exp_addr = bus.jump_addr; ihf = 1; ief = 1;
            m_bubbles_left = FC;
        end else if (bus.load_use_nop) begin
            ph = 1; ihh = 1; ief = 1;
        end
        if (ph) m_stalls = m_stalls + 1;
        exp_vec = {ph, ihh, ihf, ieh, ief, emh, emf, rd, tmo};
    endtask

    task automatic apply_reset();
        drive(5'b0, '0);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        // Park the FSM mid multicycle wait.
        for (int i = 0; i < 6; i++) begin
            drive((i == 0) ? 5'b00100 : 5'b00000, '0);
            @(negedge clk);
            predict();
            @(posedge clk);
            #1;
        end
        // Async reset with live inputs: every output must drop at once.
        #2;
        drive(5'b00011, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        checks++;
        if (act_vec() !== 9'd0 || bus.redirect_addr !== 32'd0 || bus.stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs ctl=%b addr=%h stall=%0d want all zero",
                     act_vec(), bus.redirect_addr, bus.stall_cnt);
        end
        model_clear();
        drive(5'b0, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Fresh op after release: wait counter must restart, timeout lands on cycle TO.
        for (int i = 0; i < 10; i++) begin
            drive((i == 0) ? 5'b00100 : 5'b00000, '0);
            @(negedge clk);
            predict();
            checks++;
            if (act_vec() !== exp_vec || bus.redirect_addr !== exp_addr) begin
                failures++;
                $display("FAIL reset_restart step=%0d ctl=%b want %b", i, act_vec(), exp_vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        logic [4:0] seq [3] = '{5'b00001, 5'b00000, 5'b00000};
        apply_reset();
        foreach (seq[i]) begin
            drive(seq[i], '0);
            @(negedge clk);
            predict();
            checks++;
            if (act_vec() !== exp_vec || bus.redirect_addr !== exp_addr) begin
                failures++;
                $display("FAIL load_use step=%0d ctl=%b want %b", i, act_vec(), exp_vec);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jump();
        logic [4:0] seq [4] = '{5'b00011, 5'b00001, 5'b00000, 5'b00000};
        int flushes, holds, redirs;
        flushes = 0; holds = 0; redirs = 0;
        apply_reset();
        foreach (seq[i]) begin
            drive(seq[i], 32'h0000_0100);
            @(negedge clk);
            predict();
            checks++;
            if (act_vec() !== exp_vec || bus.redirect_addr !== exp_addr) begin
                failures++;
                $display("FAIL jump step=%0d ctl=%b addr=%h want %b %h",
                         i, act_vec(), bus.redirect_addr, exp_vec, exp_addr);
            end
            if (bus.if_id_flush && bus.id_ex_flush) flushes++;
            if (bus.pc_hold) holds++;
            if (bus.redirect_en && bus.redirect_addr == 32'h0000_0100) redirs++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (flushes != 2 || holds != 0 || redirs != 1) begin
            failures++;
            $display("FAIL jump_totals flush=%0d hold=%0d redir=%0d want 2 0 1",
                     flushes, holds, redirs);
        end
    endtask

    task automatic test_multicycle();
        logic [4:0] seq [8] = '{5'b00100, 5'b00000, 5'b00000, 5'b10000,
                                5'b00000, 5'b00000, 5'b01000, 5'b00000};
        int holds, tmos, all_hold_c3;
        holds = 0; tmos = 0; all_hold_c3 = 0;
        apply_reset();
        foreach (seq[i]) begin
            drive(seq[i], '0);
            @(negedge clk);
            predict();
            checks++;
            if (act_vec() !== exp_vec || bus.redirect_addr !== exp_addr) begin
                failures++;
                $display("FAIL multicycle step=%0d ctl=%b want %b", i, act_vec(), exp_vec);
            end
            if (bus.pc_hold) holds++;
            if (bus.mc_timeout) tmos++;
            if (i == 3 && bus.ex_mem_hold && bus.pc_hold && !bus.ex_mem_flush) all_hold_c3 = 1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (holds != 6 || tmos != 0 || all_hold_c3 != 1) begin
            failures++;
            $display("FAIL multicycle_totals holds=%0d tmo=%0d allhold=%0d want 6 0 1",
                     holds, tmos, all_hold_c3);
        end
    endtask

    task automatic test_timeout();
        int pulse_at;
        pulse_at = -1;
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            // Load-use on the cycle after the pulse shows the FSM is back in RUN.
            drive((i == 0) ? 5'b00100 : ((i == 9) ? 5'b00001 : 5'b00000), '0);
            @(negedge clk);
            predict();
            checks++;
            if (act_vec() !== exp_vec || bus.redirect_addr !== exp_addr) begin
                failures++;
                $display("FAIL timeout step=%0d ctl=%b want %b", i, act_vec(), exp_vec);
            end
            if (bus.mc_timeout && pulse_at < 0) pulse_at = i;
            @(posedge clk);
            #1;
        end
        checks++;
        if (pulse_at != int'(TO)) begin
            failures++;
            $display("FAIL timeout_cycle got=%0d want=%0d", pulse_at, TO);
        end
    endtask

    task automatic test_perf();
        logic [31:0] want;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i[0] ? 5'b00000 : 5'b00001, '0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
`ifdef PIPE_CTRL_PERF_EN
        want = 32'd3;
`else
        want = 32'd0;
`endif
        checks++;
        if (bus.stall_cnt !== want) begin
            failures++;
            $display("FAIL perf_count got=%0d want=%0d", bus.stall_cnt, want);
        end
    endtask

    task automatic test_random();
        logic [4:0] s;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            s[4] = ($urandom_range(0, 99) < 15);
            s[3] = ($urandom_range(0, 99) < 15);
            s[2] = ($urandom_range(0, 99) < 10);
            s[1] = ($urandom_range(0, 99) < 15);
            s[0] = ($urandom_range(0, 99) < 25);
            drive(s, $urandom);
            @(negedge clk);
            predict();
            checks += 2;
            if (act_vec() !== exp_vec || bus.redirect_addr !== exp_addr) begin
                failures++;
                $display("FAIL random cyc=%0d in=%b ctl=%b addr=%h want %b %h",
                         i, s, act_vec(), bus.redirect_addr, exp_vec, exp_addr);
            end
            if (bus.stall_cnt !== exp_stall) begin
                failures++;
                $display("FAIL random_stall cyc=%0d got=%0d want=%0d", i, bus.stall_cnt, exp_stall);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        drive(5'b0, '0);
        model_clear();
        test_reset();
        test_load_use();
        test_jump();
        test_multicycle();
        test_timeout();
        test_perf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
